seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receiver for the team's active-low 7-segment digit bus: the inverse of the hex-to-segment encoder.
- Watches a multiplexed display bus of segment lines plus active-low one-hot digit enables, and waits for each digit's pattern to be stable.
- Decodes each stable pattern back to a 4-bit hex value and keeps a per-digit register bank with valid, blank and error status.
- Used for loopback checking of display drivers and for reading external 7-segment sources.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE_CYC, 4, consecutive identical cycles required before capture (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg_n  in  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- an_n  in  NDIG  digit enables, active-low, exactly one low when valid.
- hex_out  out  4*NDIG  decoded values; digit i at [4i+3:4i].
- valid_mask  out  NDIG  digit holds a successfully decoded value.
- blank_mask  out  NDIG  last capture for digit was all-off (7'h7F).
- err_mask  out  NDIG  last capture for digit was an unknown pattern.
- upd  out  1  one-cycle pulse on any capture.
- upd_idx  out  3  digit index of the capture flagged by upd.

Behaviour:
- Decode table (seg_n to value), fixed, shared with the encoder:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=B
  - 0110001=C, 1000010=D, 0110000=E, 0111000=F
- Input sampling:
  - seg_n and an_n are registered once; all logic acts on the registered copies.
  - Input-to-upd latency is 1 + STABLE_CYC cycles after the bus settles.
- Select validity: an_n is valid only if exactly one bit is low. Otherwise (zero or multiple low) the FSM goes to WAIT and the counter clears.
- FSM states: WAIT, COUNT, HELD.
  - WAIT: on a valid select, latch {seg, idx}, set cnt=1, go to COUNT.
  - COUNT: if {seg, idx} equals the latched value, cnt++; otherwise re-latch with cnt=1 and stay in COUNT.
  - COUNT: when cnt reaches STABLE_CYC, capture and go to HELD.
  - HELD: no recapture while the input is unchanged. On any change to a valid select, re-latch with cnt=1 and go to COUNT. On an invalid select, go to WAIT.
- Capture for digit i, with upd=1 and upd_idx=i on the following cycle:
  - Table hit: hex_out[i] = value, valid=1, blank=0, err=0.
  - seg=7'h7F: blank=1, valid=0, err=0, hex_out[i] held.
  - Any other pattern: err=1, valid=0, blank=0, hex_out[i] held.
- Other digits are never modified by a capture.
- Counter saturates at STABLE_CYC and never wraps.
- Reset, including mid-COUNT: state=WAIT, cnt=0, hex_out=0, valid_mask=0, blank_mask=0, err_mask=0, upd=0, upd_idx=0. Inputs are not sampled during reset; the sampling registers reset to seg=7'h7F and an_n all ones.
- Simultaneous events:
  - If a capture and a bus change occur on the same cycle, the capture completes. The change starts a new COUNT on the next cycle.
  - rst has priority over everything.

Decomposition:
- Package seg7_pkg:
  - Segment bit-order localparams.
  - The 16-entry pattern constants SEG_0..SEG_F and SEG_BLANK.
  - FSM state encoding.
- Sub-module seg7_pattern_decode (combinational): seg_n[6:0] to {hit, blank, val[3:0]}. The encoder can share the same constants.

Test Plan:
- Reset mid-COUNT (rst high during count) -> next cycle all outputs 0, state WAIT, no upd.
- an_n=4'b1110, seg_n=7'b0010010 held for 5 cycles (STABLE_CYC=4) -> one upd with upd_idx=0; hex_out[3:0]=2, valid_mask=4'b0001; no second upd while held.
- Scan all 16 table patterns on digit 2 (an_n=4'b1011), each held 6 cycles -> hex_out[11:8] steps 0..F with 16 upd pulses; err_mask and blank_mask stay 0.
- Glitch: digit 1 shows 7'b0000110 for 3 cycles, 7'b0000000 for 1 cycle, then 7'b0000110 for 4 cycles -> exactly one upd, value 3, and no capture of 8.
- Unknown pattern 7'b1111110 stable on digit 3 after a prior value 5 -> err_mask[3]=1, valid_mask[3]=0, hex_out[15:12] stays 5. Then 7'h7F -> blank_mask[3]=1, err_mask[3]=0.
- an_n=4'b1100 or 4'b1111 held for 10 cycles -> no upd and no output change; returning to 4'b0111 captures after STABLE_CYC cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the active-low 7-segment digit bus: segment bit order,
// the hex glyph table (also used by the encoder) and the scan-decoder FSM states.
package seg7_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    // Active-low glyphs, {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder: maps an active-low
// segment pattern to its hex value, flagging table hits and the all-off pattern.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic       blank,
    output logic [3:0] val
);

    always_comb begin
        hit   = 1'b1;
        val   = 4'h0;
        blank = (seg_n == SEG_BLANK);
        case (seg_n)
            SEG_0:   val = 4'h0;
            SEG_1:   val = 4'h1;
            SEG_2:   val = 4'h2;
            SEG_3:   val = 4'h3;
            SEG_4:   val = 4'h4;
            SEG_5:   val = 4'h5;
            SEG_6:   val = 4'h6;
            SEG_7:   val = 4'h7;
            SEG_8:   val = 4'h8;
            SEG_9:   val = 4'h9;
            SEG_A:   val = 4'hA;
            SEG_B:   val = 4'hB;
            SEG_C:   val = 4'hC;
            SEG_D:   val = 4'hD;
            SEG_E:   val = 4'hE;
            SEG_F:   val = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for a multiplexed active-low 7-segment bus: waits for each digit's
// pattern to be stable for STABLE_CYC samples, then decodes it into a per-digit bank.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     an_n,
    output logic [4*NDIG-1:0]   hex_out,
    output logic [NDIG-1:0]     valid_mask,
    output logic [NDIG-1:0]     blank_mask,
    output logic [NDIG-1:0]     err_mask,
    output logic                upd,
    output logic [2:0]          upd_idx
);

    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYC);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

    logic [6:0]      seg_r;
    logic [NDIG-1:0] an_r;
    state_t          state, state_nxt;
    logic [6:0]      lat_seg, lat_seg_nxt;
    logic [2:0]      lat_idx, lat_idx_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            capture;
    logic [3:0]      low_cnt;
    logic [2:0]      sel_idx;
    logic            sel_valid;
    logic            same;
    logic            dec_hit;
    logic            dec_blank;
    logic [3:0]      dec_val;

    // Input sampling stage: all decisions use these registered copies
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            an_r  <= '1;
        end else begin
            seg_r <= seg_n;
            an_r  <= an_n;
        end
    end

    always_comb begin
        low_cnt = 4'd0;
        sel_idx = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_r[i]) begin
                low_cnt = low_cnt + 4'd1;
                sel_idx = 3'(i);
            end
        end
    end

    assign sel_valid = (low_cnt == 4'd1);
    assign same      = (seg_r == lat_seg) && (sel_idx == lat_idx);

    always_comb begin
        state_nxt   = state;
        lat_seg_nxt = lat_seg;
        lat_idx_nxt = lat_idx;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        if (!sel_valid) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    lat_seg_nxt = seg_r;
                    lat_idx_nxt = sel_idx;
                    cnt_nxt     = 8'd1;
                    state_nxt   = ST_COUNT;
                end
                ST_COUNT: begin
                    if (!same) begin
                        lat_seg_nxt = seg_r;
                        lat_idx_nxt = sel_idx;
                        cnt_nxt     = 8'd1;
                    end else if (cnt >= CNT_LAST) begin
                        // Reaching the threshold is the capture; count parks there
                        cnt_nxt   = CNT_MAX;
                        capture   = 1'b1;
                        state_nxt = ST_HELD;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                ST_HELD: begin
                    if (!same) begin
                        lat_seg_nxt = seg_r;
                        lat_idx_nxt = sel_idx;
                        cnt_nxt     = 8'd1;
                        state_nxt   = ST_COUNT;
                    end
                end
                default: begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_WAIT;
            cnt     <= 8'd0;
            lat_seg <= SEG_BLANK;
            lat_idx <= 3'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lat_seg <= lat_seg_nxt;
            lat_idx <= lat_idx_nxt;
        end
    end

    // Capture decodes the latched pattern, which equals the current one on a capture
    seg7_pattern_decode u_decode (
        .seg_n (lat_seg_nxt),
        .hit   (dec_hit),
        .blank (dec_blank),
        .val   (dec_val)
    );

    // Register bank stage: only the captured digit is touched
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_out    <= '0;
            valid_mask <= '0;
            blank_mask <= '0;
            err_mask   <= '0;
            upd        <= 1'b0;
            upd_idx    <= 3'd0;
        end else begin
            upd <= capture;
            if (capture) begin
                upd_idx <= lat_idx_nxt;
            end
            for (int i = 0; i < NDIG; i++) begin
                if (capture && (lat_idx_nxt == 3'(i))) begin
                    if (dec_hit) begin
                        hex_out[4*i +: 4] <= dec_val;
                        valid_mask[i]     <= 1'b1;
                        blank_mask[i]     <= 1'b0;
                        err_mask[i]       <= 1'b0;
                    end else if (dec_blank) begin
                        valid_mask[i] <= 1'b0;
                        blank_mask[i] <= 1'b1;
                        err_mask[i]   <= 1'b0;
                    end else begin
                        valid_mask[i] <= 1'b0;
                        blank_mask[i] <= 1'b0;
                        err_mask[i]   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=4, STABLE_CYC=4) with hand-computed expectations.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] hex_out;
    logic [3:0]  valid_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        upd;
    logic [2:0]  upd_idx;

    int passed = 0;
    int total  = 0;
    int upd_count = 0;
    int first_upd_cyc = 0;
    logic [2:0] last_idx = 3'd0;
    logic [3:0] last_val = 4'd0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .hex_out    (hex_out),
        .valid_mask (valid_mask),
        .blank_mask (blank_mask),
        .err_mask   (err_mask),
        .upd        (upd),
        .upd_idx    (upd_idx)
    );

    always #5 clk = ~clk;

    // Drive a bus value for n cycles, sampling 1 time unit after each rising edge
    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        seg_n = s;
        an_n  = a;
        first_upd_cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) begin
                upd_count++;
                last_idx = upd_idx;
                last_val = hex_out[upd_idx*4 +: 4];
                if (first_upd_cyc == 0) first_upd_cyc = i + 1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hold(7'h7F, 4'b1111, 3);
        total++; if (hex_out !== 16'h0) $display("FAIL reset_hex: got %h want 0000", hex_out); else passed++;
        total++; if ({valid_mask, blank_mask, err_mask} !== 12'h0) $display("FAIL reset_masks: got %h want 000", {valid_mask, blank_mask, err_mask}); else passed++;
        total++; if ({upd, upd_idx} !== 4'h0) $display("FAIL reset_upd: got %h want 0", {upd, upd_idx}); else passed++;
        rst = 1'b0;
        hold(7'h7F, 4'b1111, 2);
    endtask

    task automatic test_single_capture;
        int base;
        base = upd_count;
        hold(7'b0010010, 4'b1110, 5);
        total++; if (first_upd_cyc !== 5) $display("FAIL single_latency: got cycle %0d want 5", first_upd_cyc); else passed++;
        total++; if (upd_count - base !== 1) $display("FAIL single_count: got %0d want 1", upd_count - base); else passed++;
        total++; if (last_idx !== 3'd0) $display("FAIL single_idx: got %0d want 0", last_idx); else passed++;
        total++; if (hex_out[3:0] !== 4'h2) $display("FAIL single_hex: got %h want 2", hex_out[3:0]); else passed++;
        total++; if (valid_mask !== 4'b0001) $display("FAIL single_valid: got %b want 0001", valid_mask); else passed++;
        hold(7'b0010010, 4'b1110, 5);
        total++; if (upd_count - base !== 1) $display("FAIL single_no_recapture: got %0d want 1", upd_count - base); else passed++;
        hold(7'h7F, 4'b1111, 2);
    endtask

    task automatic test_reset_mid_count;
        int base;
        hold(7'b0000110, 4'b1101, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (hex_out !== 16'h0) $display("FAIL midrst_hex: got %h want 0000", hex_out); else passed++;
        total++; if ({valid_mask, blank_mask, err_mask} !== 12'h0) $display("FAIL midrst_masks: got %h want 000", {valid_mask, blank_mask, err_mask}); else passed++;
        total++; if ({upd, upd_idx} !== 4'h0) $display("FAIL midrst_upd: got %h want 0", {upd, upd_idx}); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        base = upd_count;
        hold(7'b0000110, 4'b1101, 3);
        hold(7'h7F, 4'b1111, 6);
        total++; if (upd_count !== base) $display("FAIL midrst_count_cleared: got %0d upd want 0", upd_count - base); else passed++;
    endtask

    task automatic test_scan_all;
        int base;
        base = upd_count;
        for (int v = 0; v < 16; v++) begin
            hold(glyph[v], 4'b1011, 6);
            total++;
            if (hex_out[11:8] !== 4'(v)) $display("FAIL scan_hex_%0d: got %h want %h", v, hex_out[11:8], 4'(v));
            else passed++;
        end
        hold(7'h7F, 4'b1111, 2);
        total++; if (upd_count - base !== 16) $display("FAIL scan_count: got %0d want 16", upd_count - base); else passed++;
        total++; if ({blank_mask, err_mask} !== 8'h0) $display("FAIL scan_flags: got %h want 00", {blank_mask, err_mask}); else passed++;
        total++; if (valid_mask !== 4'b0100) $display("FAIL scan_valid: got %b want 0100", valid_mask); else passed++;
        total++; if ({hex_out[15:12], hex_out[7:0]} !== 12'h0) $display("FAIL scan_others: got %h want 000", {hex_out[15:12], hex_out[7:0]}); else passed++;
    endtask

    task automatic test_glitch;
        int base;
        base = upd_count;
        hold(7'b0000110, 4'b1101, 3);
        hold(7'b0000000, 4'b1101, 1);
        hold(7'b0000110, 4'b1101, 4);
        hold(7'h7F, 4'b1111, 6);
        total++; if (upd_count - base !== 1) $display("FAIL glitch_count: got %0d want 1", upd_count - base); else passed++;
        total++; if (last_val !== 4'h3) $display("FAIL glitch_value: got %h want 3", last_val); else passed++;
        total++; if (last_idx !== 3'd1) $display("FAIL glitch_idx: got %0d want 1", last_idx); else passed++;
        total++; if (hex_out[7:4] !== 4'h3) $display("FAIL glitch_hex: got %h want 3", hex_out[7:4]); else passed++;
    endtask

    task automatic test_err_blank;
        hold(7'b0100100, 4'b0111, 6);
        total++; if (hex_out[15:12] !== 4'h5) $display("FAIL eb_prior: got %h want 5", hex_out[15:12]); else passed++;
        hold(7'b1111110, 4'b0111, 6);
        total++; if (err_mask[3] !== 1'b1) $display("FAIL eb_err: got %b want 1", err_mask[3]); else passed++;
        total++; if (valid_mask !== 4'b0110) $display("FAIL eb_valid: got %b want 0110", valid_mask); else passed++;
        total++; if (hex_out[15:12] !== 4'h5) $display("FAIL eb_hex_held: got %h want 5", hex_out[15:12]); else passed++;
        hold(7'h7F, 4'b0111, 6);
        total++; if ({blank_mask[3], err_mask[3], valid_mask[3]} !== 3'b100) $display("FAIL eb_blank: got %b want 100", {blank_mask[3], err_mask[3], valid_mask[3]}); else passed++;
        total++; if (hex_out[15:12] !== 4'h5) $display("FAIL eb_blank_hex: got %h want 5", hex_out[15:12]); else passed++;
        hold(7'h7F, 4'b1111, 2);
    endtask

    task automatic test_invalid_select;
        int base;
        logic [27:0] snap;
        base = upd_count;
        snap = {hex_out, valid_mask, blank_mask, err_mask};
        hold(7'b0001111, 4'b1100, 10);
        hold(7'b0001111, 4'b1111, 10);
        total++; if (upd_count !== base) $display("FAIL inv_no_upd: got %0d upd want 0", upd_count - base); else passed++;
        total++; if ({hex_out, valid_mask, blank_mask, err_mask} !== snap) $display("FAIL inv_no_change: got %h want %h", {hex_out, valid_mask, blank_mask, err_mask}, snap); else passed++;
        hold(7'b0001111, 4'b0111, 6);
        total++; if (first_upd_cyc !== 5) $display("FAIL inv_resume_latency: got cycle %0d want 5", first_upd_cyc); else passed++;
        total++; if (hex_out[15:12] !== 4'h7) $display("FAIL inv_resume_hex: got %h want 7", hex_out[15:12]); else passed++;
        total++; if ({valid_mask[3], blank_mask[3]} !== 2'b10) $display("FAIL inv_resume_flags: got %b want 10", {valid_mask[3], blank_mask[3]}); else passed++;
    endtask

    initial begin
        rst   = 1'b1;
        seg_n = 7'h7F;
        an_n  = 4'b1111;
        test_reset;
        test_single_capture;
        test_reset_mid_count;
        test_scan_all;
        test_glitch;
        test_err_blank;
        test_invalid_select;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
